sc_register_bank: RTL and testbench

Register bank at the receiving end of the register-address path. It takes the 6-bit A, B and C addresses produced by the datapath's address multiplexers (either MIR fields or zero-extended 5-bit scratchpad fields). It decodes them into two combinational read ports and one clocked write port. It holds the 32 user registers %r0–%r31 and the six microcode temporaries %r32–%r37, and flags illegal write addresses.

---
 rtl/sc_register_bank_pkg.sv | 17 +
 rtl/sc_register_bank_decoder.sv | 24 ++
 rtl/sc_register_bank.sv | 94 +++++++++
 tb/tb_sc_register_bank.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sc_register_bank_pkg.sv
// Shared sizing defaults and named register addresses for the register bank
// and its write decoder.
package sc_register_bank_pkg;

    localparam int DATAWIDTH_BUS       = 32;
    localparam int DATAWIDTH_DIRECTION = 6;
    localparam int NUM_REGS            = 38;

    localparam logic [DATAWIDTH_DIRECTION-1:0] REG_ZERO  = 6'd0;
    localparam logic [DATAWIDTH_DIRECTION-1:0] REG_PC    = 6'd32;
    localparam logic [DATAWIDTH_DIRECTION-1:0] REG_TEMP0 = 6'd33;
    localparam logic [DATAWIDTH_DIRECTION-1:0] REG_TEMP1 = 6'd34;
    localparam logic [DATAWIDTH_DIRECTION-1:0] REG_TEMP2 = 6'd35;
    localparam logic [DATAWIDTH_DIRECTION-1:0] REG_TEMP3 = 6'd36;
    localparam logic [DATAWIDTH_DIRECTION-1:0] REG_IR    = 6'd37;

endpackage

// File: rtl/sc_register_bank_decoder.sv
// One-hot write decoder for the C port. Each load line is gated by the write
// enable; in_range tells the error logic whether the address is implemented.
module sc_register_bank_decoder
    import sc_register_bank_pkg::*;
#(
    parameter int ADDR_W  = sc_register_bank_pkg::DATAWIDTH_DIRECTION,
    parameter int N_LINES = sc_register_bank_pkg::NUM_REGS
) (
    input  logic [ADDR_W-1:0]  addr,
    input  logic               write_en,
    output logic [N_LINES-1:0] load,
    output logic               in_range
);

    always_comb begin
        load = '0;
        for (int i = 0; i < N_LINES; i++) begin
            load[i] = write_en && (addr == ADDR_W'(i));
        end
    end

    assign in_range = (int'(addr) < N_LINES);

endmodule

// File: rtl/sc_register_bank.sv
// Register bank: %r0 hardwired to zero, %r1..%r37 stored, two combinational
// read ports, one falling-edge write port with sticky illegal-write flag.
module sc_register_bank
    import sc_register_bank_pkg::*;
#(
    parameter int DATAWIDTH_BUS       = sc_register_bank_pkg::DATAWIDTH_BUS,
    parameter int DATAWIDTH_DIRECTION = sc_register_bank_pkg::DATAWIDTH_DIRECTION,
    parameter int NUM_REGS            = sc_register_bank_pkg::NUM_REGS
) (
    input  logic                           SC_REGISTER_BANK_CLOCK_50,
    input  logic                           SC_REGISTER_BANK_ResetInHigh_In,
    input  logic                           SC_REGISTER_BANK_Write_In,
    input  logic [DATAWIDTH_DIRECTION-1:0] SC_REGISTER_BANK_CAddress_InBus,
    input  logic [DATAWIDTH_BUS-1:0]       SC_REGISTER_BANK_CData_InBus,
    input  logic [DATAWIDTH_DIRECTION-1:0] SC_REGISTER_BANK_AAddress_InBus,
    input  logic [DATAWIDTH_DIRECTION-1:0] SC_REGISTER_BANK_BAddress_InBus,
    output logic [DATAWIDTH_BUS-1:0]       SC_REGISTER_BANK_AData_OutBus,
    output logic [DATAWIDTH_BUS-1:0]       SC_REGISTER_BANK_BData_OutBus,
    output logic                           SC_REGISTER_BANK_WriteError_Out,
    output logic [DATAWIDTH_DIRECTION-1:0] SC_REGISTER_BANK_LastWriteAddr_OutBus
);

    logic [NUM_REGS-1:0]            load;
    logic                           c_in_range;

    logic [DATAWIDTH_BUS-1:0]       regs_q [NUM_REGS];
    logic [DATAWIDTH_BUS-1:0]       regs_d [NUM_REGS];
    logic                           write_error_q, write_error_d;
    logic [DATAWIDTH_DIRECTION-1:0] last_addr_q, last_addr_d;

    sc_register_bank_decoder #(
        .ADDR_W  (DATAWIDTH_DIRECTION),
        .N_LINES (NUM_REGS)
    ) u_decoder (
        .addr     (SC_REGISTER_BANK_CAddress_InBus),
        .write_en (SC_REGISTER_BANK_Write_In),
        .load     (load),
        .in_range (c_in_range)
    );

    // Slot 0 is never loaded, so %r0 stays zero while writes to it still count
    // as accepted for LastWriteAddr.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (i != int'(REG_ZERO) && load[i]) begin
                regs_d[i] = SC_REGISTER_BANK_CData_InBus;
            end
        end
        regs_d[REG_ZERO] = '0;

        write_error_d = write_error_q
                      | (SC_REGISTER_BANK_Write_In & ~c_in_range);

        last_addr_d = last_addr_q;
        if (SC_REGISTER_BANK_Write_In && c_in_range) begin
            last_addr_d = SC_REGISTER_BANK_CAddress_InBus;
        end
    end

    always_ff @(negedge SC_REGISTER_BANK_CLOCK_50 or posedge SC_REGISTER_BANK_ResetInHigh_In) begin
        if (SC_REGISTER_BANK_ResetInHigh_In) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            write_error_q <= 1'b0;
            last_addr_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            write_error_q <= write_error_d;
            last_addr_q   <= last_addr_d;
        end
    end

    // Read ports: unimplemented addresses fall through to zero.
    always_comb begin
        SC_REGISTER_BANK_AData_OutBus = '0;
        SC_REGISTER_BANK_BData_OutBus = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (SC_REGISTER_BANK_AAddress_InBus == DATAWIDTH_DIRECTION'(i)) begin
                SC_REGISTER_BANK_AData_OutBus = regs_q[i];
            end
            if (SC_REGISTER_BANK_BAddress_InBus == DATAWIDTH_DIRECTION'(i)) begin
                SC_REGISTER_BANK_BData_OutBus = regs_q[i];
            end
        end
    end

    assign SC_REGISTER_BANK_WriteError_Out       = write_error_q;
    assign SC_REGISTER_BANK_LastWriteAddr_OutBus = last_addr_q;

endmodule

// File: tb/tb_sc_register_bank.sv
// Directed and random checks of sc_register_bank against an array model of
// the register file, error flag and last-write address.
module tb_sc_register_bank;

    localparam int NREG = 38;

    logic        clk;
    logic        rst;
    logic        we;
    logic [5:0]  c_addr;
    logic [31:0] c_data;
    logic [5:0]  a_addr;
    logic [5:0]  b_addr;
    logic [31:0] a_data;
    logic [31:0] b_data;
    logic        wr_err;
    logic [5:0]  last_addr;

    logic [31:0] mem [NREG];
    logic        m_err;
    logic [5:0]  m_last;

    int n_checks = 0;
    int n_pass   = 0;

    sc_register_bank dut (
        .SC_REGISTER_BANK_CLOCK_50             (clk),
        .SC_REGISTER_BANK_ResetInHigh_In       (rst),
        .SC_REGISTER_BANK_Write_In             (we),
        .SC_REGISTER_BANK_CAddress_InBus       (c_addr),
        .SC_REGISTER_BANK_CData_InBus          (c_data),
        .SC_REGISTER_BANK_AAddress_InBus       (a_addr),
        .SC_REGISTER_BANK_BAddress_InBus       (b_addr),
        .SC_REGISTER_BANK_AData_OutBus         (a_data),
        .SC_REGISTER_BANK_BData_OutBus         (b_data),
        .SC_REGISTER_BANK_WriteError_Out       (wr_err),
        .SC_REGISTER_BANK_LastWriteAddr_OutBus (last_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] addr);
        if (addr == 6'd0 || int'(addr) >= NREG) return 32'h0;
        return mem[addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mem[i] = 32'h0;
        m_err  = 1'b0;
        m_last = 6'd0;
    endtask

    task automatic model_write(input logic w, input logic [5:0] c, input logic [31:0] d);
        if (!w) return;
        if (int'(c) >= NREG) begin
            m_err = 1'b1;
        end else begin
            if (c != 6'd0) mem[c] = d;
            m_last = c;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".a"},    a_data, model_read(a_addr));
        check({tag, ".b"},    b_data, model_read(b_addr));
        check({tag, ".err"},  {31'b0, wr_err}, {31'b0, m_err});
        check({tag, ".last"}, {26'b0, last_addr}, {26'b0, m_last});
    endtask

    // Drive mid-cycle, confirm old data before the falling edge, new data after.
    task automatic do_cycle(input logic w, input logic [5:0] c, input logic [31:0] d,
                            input logic [5:0] a, input logic [5:0] b, input string tag);
        @(posedge clk);
        #1;
        we = w; c_addr = c; c_data = d; a_addr = a; b_addr = b;
        #1;
        check({tag, ".pre_a"}, a_data, model_read(a));
        @(negedge clk);
        model_write(w, c, d);
        #1;
        check_outputs(tag);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < NREG; i++) begin
            a_addr = 6'(i);
            b_addr = 6'(NREG - 1 - i);
            #1;
            check({tag, ".sa"}, a_data, model_read(a_addr));
            check({tag, ".sb"}, b_data, model_read(b_addr));
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; c_addr = '0; c_data = '0; a_addr = 6'd5; b_addr = 6'd37;
        model_reset();
        #12;
        check_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        do_cycle(1'b1, 6'd5,  32'hDEADBEEF, 6'd5, 6'd5,  "wr5");
        do_cycle(1'b1, 6'd0,  32'h12345678, 6'd0, 6'd5,  "wr0");
        do_cycle(1'b1, 6'd10, 32'h0BADF00D, 6'd10, 6'd0, "wr10");
        do_cycle(1'b1, 6'd45, 32'hAAAA5555, 6'd45, 6'd5, "wr45");
        sweep("after45");
        for (int k = 0; k < 10; k++) begin
            do_cycle(1'b1, 6'($urandom_range(1, NREG - 1)), $urandom,
                     6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), "sticky");
        end
        do_cycle(1'b1, 6'd32, 32'hC0DE0032, 6'd32, 6'd37, "wr_pc");
        do_cycle(1'b1, 6'd37, 32'hC0DE0037, 6'd32, 6'd37, "wr_ir");
        for (int k = 0; k < 5; k++) begin
            do_cycle(1'b0, 6'($urandom_range(0, 63)), $urandom, 6'd32, 6'd37, "nowe");
        end
        sweep("after_nowe");

        // Asynchronous reset between edges with a write pending on %r10.
        @(posedge clk);
        #1;
        we = 1'b1; c_addr = 6'd10; c_data = 32'hFFFFFFFF; a_addr = 6'd10; b_addr = 6'd32;
        #1 rst = 1'b1;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(negedge clk);
        #1;
        check_outputs("rst_held");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        model_write(1'b1, 6'd10, 32'hFFFFFFFF);
        #1;
        check_outputs("post_rst");

        for (int k = 0; k < 300; k++) begin
            logic [5:0] c;
            c = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                            : 6'($urandom_range(0, NREG - 1));
            do_cycle(1'($urandom_range(0, 3) != 0), c, $urandom,
                     6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), "rand");
        end
        sweep("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
